// File: rtl/cpu_trace_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_trace_monitor_if                                                     |
// | Core sample, run control and trace read port bundle for the monitor.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cpu_trace_monitor_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 16
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic                   start;
    logic                   sample_en;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [DATA_WIDTH-1:0]  result;
    logic [PC_WIDTH-1:0]    pc_limit;
    logic                   wrap_mode;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [PC_WIDTH-1:0]    rd_pc;
    logic [INSTR_WIDTH-1:0] rd_instr;
    logic [DATA_WIDTH-1:0]  rd_result;
    logic [c_CW-1:0]        count;
    logic                   running;
    logic                   done;
    logic                   overflow;
    logic [CNT_WIDTH-1:0]   cycle_count;

    modport master (
        output start, sample_en, pc, instruction, result, pc_limit, wrap_mode, rd_ready,
        input  rd_valid, rd_pc, rd_instr, rd_result, count, running, done, overflow, cycle_count
    );

    modport slave (
        input  start, sample_en, pc, instruction, result, pc_limit, wrap_mode, rd_ready,
        output rd_valid, rd_pc, rd_instr, rd_result, count, running, done, overflow, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_trace_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_trace_monitor                                                        |
// | Run controller with PC-limit stop and a FWFT circular trace FIFO.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpu_trace_monitor #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    cpu_trace_monitor_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_EW = PC_WIDTH + INSTR_WIDTH + DATA_WIDTH;
    localparam logic [c_CW-1:0]      c_FULL    = c_CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_EW-1:0]      r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_cycle_count;

    logic            w_limit_hit;
    logic            w_in_run;
    logic            w_capture;
    logic            w_rd_valid;
    logic            w_pop;
    logic            w_full;
    logic            w_wr_en;
    logic            w_drop;
    logic            w_overwrite;
    logic [c_EW-1:0] w_head;

    assign w_limit_hit = (bus.pc >= bus.pc_limit);
    assign w_in_run    = (r_state == S_RUN);
    assign w_rd_valid  = (r_count != '0);
    assign w_full      = (r_count == c_FULL);
    // A start edge flushes the FIFO, so neither capture nor pop may act on it.
    assign w_capture   = w_in_run && !bus.start && !w_limit_hit && bus.sample_en;
    assign w_pop       = w_rd_valid && bus.rd_ready && !bus.start;
    assign w_drop      = w_capture && w_full && !w_pop;
    assign w_overwrite = w_drop && bus.wrap_mode;
    assign w_wr_en     = w_capture && (!w_full || w_pop || bus.wrap_mode);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = S_RUN;
        end else if (w_in_run && w_limit_hit) begin
            w_state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_cycle_count <= '0;
        end else if (bus.start) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_capture && !w_full && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_capture) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_in_run && !w_limit_hit && (r_cycle_count != c_CNT_MAX)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
        end
    end

    // Trace storage carries no reset; the read port masks it while empty.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {bus.pc, bus.instruction, bus.result};
        end
    end

    assign w_head = w_rd_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.rd_valid    = w_rd_valid;
    assign bus.rd_pc       = w_head[c_EW-1 -: PC_WIDTH];
    assign bus.rd_instr    = w_head[DATA_WIDTH +: INSTR_WIDTH];
    assign bus.rd_result   = w_head[DATA_WIDTH-1:0];
    assign bus.count       = r_count;
    assign bus.running     = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.overflow    = r_overflow;
    assign bus.cycle_count = r_cycle_count;
endmodule
`default_nettype wire
